// File: rtl/imem_ahb_arbiter.sv
// Two-port arbiter sharing the instruction SRAM AHB slave between fetch (m0) and loader (m1).
// Define IMEM_ARB_RR_EN for round-robin tie-breaking; otherwise m0 has fixed priority.
module imem_ahb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  hclk_i,
    input  logic                  hreset_i,
    input  logic                  m0_hsel_i,
    input  logic [DATA_WIDTH-1:0] m0_haddr_i,
    input  logic                  m0_hwrite_i,
    input  logic [DATA_WIDTH-1:0] m0_hwdata_i,
    output logic [DATA_WIDTH-1:0] m0_hrdata_o,
    output logic                  m0_hready_o,
    output logic                  m0_hresp_o,
    input  logic                  m1_hsel_i,
    input  logic [DATA_WIDTH-1:0] m1_haddr_i,
    input  logic                  m1_hwrite_i,
    input  logic [DATA_WIDTH-1:0] m1_hwdata_i,
    output logic [DATA_WIDTH-1:0] m1_hrdata_o,
    output logic                  m1_hready_o,
    output logic                  m1_hresp_o,
    output logic                  s_hsel_o,
    output logic [DATA_WIDTH-1:0] s_haddr_o,
    output logic                  s_hwrite_o,
    output logic [DATA_WIDTH-1:0] s_hwdata_o,
    input  logic [DATA_WIDTH-1:0] s_hrdata_i,
    input  logic                  s_hready_i,
    input  logic                  s_hresp_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       gnt0, gnt1, cur_hsel, timeout, pick1;

    assign gnt0     = (state_q == GNT0);
    assign gnt1     = (state_q == GNT1);
    assign cur_hsel = (gnt0 & m0_hsel_i) | (gnt1 & m1_hsel_i);
    assign timeout  = (gnt0 | gnt1) & ~s_hready_i & (cnt_q == TO_LAST);

`ifdef IMEM_ARB_RR_EN
    // last_q=1 means port 1 was granted last; reset value lets port 0 win the first tie.
    logic last_q;

    assign pick1 = m1_hsel_i & (~m0_hsel_i | ~last_q);

    always_ff @(posedge hclk_i or negedge hreset_i) begin
        if (!hreset_i) begin
            last_q <= 1'b1;
        end else if (state_q == IDLE && (m0_hsel_i || m1_hsel_i)) begin
            last_q <= pick1;
        end
    end
`else
    assign pick1 = m1_hsel_i & ~m0_hsel_i;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (m0_hsel_i || m1_hsel_i) begin
                    state_d = pick1 ? GNT1 : GNT0;
                end
            end
            GNT0, GNT1: begin
                if (!s_hready_i) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (s_hready_i || !cur_hsel || timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hclk_i or negedge hreset_i) begin
        if (!hreset_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        s_hsel_o    = 1'b0;
        s_haddr_o   = '0;
        s_hwrite_o  = 1'b0;
        s_hwdata_o  = '0;
        m0_hrdata_o = '0;
        m0_hready_o = 1'b0;
        m0_hresp_o  = 1'b0;
        m1_hrdata_o = '0;
        m1_hready_o = 1'b0;
        m1_hresp_o  = 1'b0;
        if (gnt0) begin
            // A timeout answers the master with an error and drops the slave select.
            s_hsel_o    = m0_hsel_i & ~timeout;
            s_haddr_o   = m0_haddr_i;
            s_hwrite_o  = m0_hwrite_i;
            s_hwdata_o  = m0_hwdata_i;
            m0_hrdata_o = timeout ? '0 : s_hrdata_i;
            m0_hready_o = s_hready_i | timeout;
            m0_hresp_o  = (s_hresp_i & s_hready_i) | timeout;
        end else if (gnt1) begin
            s_hsel_o    = m1_hsel_i & ~timeout;
            s_haddr_o   = m1_haddr_i;
            s_hwrite_o  = m1_hwrite_i;
            s_hwdata_o  = m1_hwdata_i;
            m1_hrdata_o = timeout ? '0 : s_hrdata_i;
            m1_hready_o = s_hready_i | timeout;
            m1_hresp_o  = (s_hresp_i & s_hready_i) | timeout;
        end
    end

endmodule
